hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Pipeline hazard controller for the 5-stage RV32I core; it is the consumer of the ID/EX register's EX-side outputs. It compares the instruction in ID against the instruction latched in EX and decides when to stall PC and IF/ID on load-use, and when to flush IF/ID and ID/EX. Flush decisions come from EX-resolved redirects (branch/jump mispredict). A small FSM covers multi-cycle load latency and redirect shadow cycles, and saturating counters report stall and flush activity.

## Interface
- LOAD_STALL, default 1: bubble cycles inserted per load-use hazard; legal range 1..7.
- REDIR_EXTRA, default 0: extra flush cycles after a redirect, covering instruction-memory latency; legal range 0..7.
- WB_SEL_LOAD, default 2'b01: wb_sel encoding that marks a load.
- CNT_W, default 32: width of each performance counter.
- i_clk  in  1  clock.
- i_rst_n  in  1  reset: asynchronous, active-low.
- i_ID_inst  in  32  instruction currently in ID.
- i_ID_insn_vld  in  1  ID instruction valid.
- i_EX_inst  in  32  instruction in EX; rd is bits [11:7].
- i_EX_rd_wren  in  1  EX instruction writes rd.
- i_EX_wb_sel  in  2  EX writeback select.
- i_EX_insn_vld  in  1  EX instruction valid.
- i_EX_redirect  in  1  EX resolved a mispredict; fetch is redirected this cycle.
- o_pc_en  out  1  PC update enable.
- o_IF_ID_en  out  1  IF/ID load enable.
- o_IF_ID_flush  out  1  IF/ID flush.
- o_ID_EX_flush  out  1  ID/EX flush (bubble insert).
- o_state  out  2  FSM state: 0=RUN, 1=LDSTALL, 2=REDIR.
- o_stall_cnt  out  CNT_W  count of load-use stall cycles, saturating.
- o_flush_cnt  out  CNT_W  count of redirect events, saturating.

## Operation
- Register-use decode from the ID opcode (bits [6:0]):
  - uses_rs1 = valid and opcode not in {LUI 0110111, AUIPC 0010111, JAL 1101111}.
  - uses_rs2 = valid and opcode in {R 0110011, S 0100011, B 1100011}.
- Load-use hazard, lu = all of the following:
  - i_EX_insn_vld, i_EX_rd_wren, and i_EX_wb_sel==WB_SEL_LOAD;
  - EX rd != 0;
  - (uses_rs1 and rs1==rd) or (uses_rs2 and rs2==rd).
- Redirect, rd_ev = i_EX_redirect & i_EX_insn_vld.
- Default outputs: o_pc_en=1, o_IF_ID_en=1, both flushes 0.
- rd_ev has priority in every state:
  - Outputs: o_IF_ID_flush=1 and o_ID_EX_flush=1; pc_en and IF_ID_en stay 1 so the redirect target loads.
  - o_flush_cnt increments.
  - If REDIR_EXTRA>0: next state REDIR, down-counter=REDIR_EXTRA. Otherwise next state RUN.
- RUN with lu and no rd_ev:
  - Outputs: o_pc_en=0, o_IF_ID_en=0, o_ID_EX_flush=1.
  - o_stall_cnt increments.
  - If LOAD_STALL>1: next state LDSTALL, counter=LOAD_STALL-1. Otherwise stay RUN; the load has left EX next cycle, so lu clears.
- LDSTALL:
  - Outputs identical to the RUN+lu case, independent of lu; o_stall_cnt increments each cycle.
  - Counter decrements; when it is 1, next state is RUN.
- REDIR:
  - Outputs: o_IF_ID_flush=1, o_ID_EX_flush=1, o_pc_en=1.
  - Counter decrements; when it is 1, next state is RUN.
  - A new rd_ev reloads counter=REDIR_EXTRA.
- Counters hold at all-ones; no wrap.

## Timing
- Outputs are Mealy: combinational from registered state/counter plus the current inputs, valid in the same cycle as the hazard. The consuming registers act on the next i_clk edge.
- State, down-counter and perf counters update on the i_clk rising edge.
- Reset (async assert, sync-to-clock deassert is external): state=RUN, down-counter=0, o_stall_cnt=0, o_flush_cnt=0.
- During reset, the outputs follow RUN decode of the inputs.
- Reset asserted mid-LDSTALL or mid-REDIR returns to RUN immediately with no residual stall.
- Load-use stall cost: exactly LOAD_STALL cycles with o_pc_en=0 per hazard.
- Redirect cost: 1 + REDIR_EXTRA cycles with both flushes high.
- Simultaneous lu and rd_ev: redirect wins, no stall, and o_stall_cnt is unchanged.
- rd_ev during LDSTALL aborts the stall in that same cycle.

## Test plan
- LW x5 in EX (wb_sel=01, rd_wren=1) and ADD x6,x5,x1 in ID, LOAD_STALL=1:
  - one cycle with pc_en=0, IF_ID_en=0, ID_EX_flush=1; stall_cnt 0->1; state stays RUN.
- Same pair with LOAD_STALL=3:
  - o_state goes 0,1,1,0; pc_en low for exactly 3 cycles; stall_cnt=3.
- No-stall cases, each must give pc_en=1 with no flush:
  - LW x0 in EX with ADD using x0 in ID;
  - LW x5 in EX with LUI x5 in ID;
  - LW x5 in EX with I-type ADDI whose bits [24:20]=5.
- Redirect with REDIR_EXTRA=2:
  - both flushes high for 3 consecutive cycles; state goes 2,2,0; flush_cnt=1.
- lu and i_EX_redirect asserted in the same cycle:
  - pc_en=1, both flushes=1, stall_cnt unchanged, flush_cnt+1.
- Reset pulse mid-LDSTALL:
  - state=0 and counters=0 within the reset cycle.
- Counter saturation, CNT_W=4:
  - 20 stall cycles leave o_stall_cnt=15.

Source files
------------

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: load-use stall and redirect flush control for the 5-stage RV32I pipeline.
// Compares the instruction in ID against the load latched in EX. When the ID instruction
// needs the load result, it holds PC and IF/ID and drops a bubble into ID/EX. It also
// flushes IF/ID and ID/EX when EX resolves a redirect.
//
// Ports:
//   i_clk, i_rst_n                  clock, async active-low reset
//   i_ID_inst, i_ID_insn_vld        instruction in ID and its valid
//   i_EX_inst, i_EX_rd_wren,        instruction in EX (rd = [11:7]), rd write enable,
//   i_EX_wb_sel, i_EX_insn_vld      writeback select, valid
//   i_EX_redirect                   EX resolved a mispredict this cycle
//   o_pc_en, o_IF_ID_en             PC / IF-ID load enables (low = stall)
//   o_IF_ID_flush, o_ID_EX_flush    pipeline register flushes
//   o_state                         FSM state
//   o_stall_cnt, o_flush_cnt        saturating stall-cycle and redirect-event counters
//
// state   | meaning
// --------+--------------------------------------------------------------
// RUN     | normal issue; stall only on a live load-use hazard
// LDSTALL | remaining bubble cycles of a multi-cycle load-use stall
// REDIR   | shadow cycles after a redirect while the new fetch returns
module hazard_ctrl #(
    parameter int         LOAD_STALL  = 1,
    parameter int         REDIR_EXTRA = 0,
    parameter logic [1:0] WB_SEL_LOAD = 2'b01,
    parameter int         CNT_W       = 32
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [31:0]      i_ID_inst,
    input  logic             i_ID_insn_vld,
    input  logic [31:0]      i_EX_inst,
    input  logic             i_EX_rd_wren,
    input  logic [1:0]       i_EX_wb_sel,
    input  logic             i_EX_insn_vld,
    input  logic             i_EX_redirect,
    output logic             o_pc_en,
    output logic             o_IF_ID_en,
    output logic             o_IF_ID_flush,
    output logic             o_ID_EX_flush,
    output logic [1:0]       o_state,
    output logic [CNT_W-1:0] o_stall_cnt,
    output logic [CNT_W-1:0] o_flush_cnt
);

    localparam logic [1:0] ST_RUN     = 2'd0;
    localparam logic [1:0] ST_LDSTALL = 2'd1;
    localparam logic [1:0] ST_REDIR   = 2'd2;

    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_S     = 7'b0100011;
    localparam logic [6:0] OP_B     = 7'b1100011;

    // Counter reload values; the first stall/flush cycle happens in the cycle that
    // detects the event, so LDSTALL covers only the remaining LOAD_STALL-1 cycles.
    localparam logic [2:0] LS_RELOAD = 3'(LOAD_STALL - 1);
    localparam logic [2:0] RE_RELOAD = 3'(REDIR_EXTRA);
    localparam logic [CNT_W-1:0] CNT_ONE = 1;

    logic [1:0]       state_q, state_nxt;
    logic [2:0]       dcnt_q, dcnt_nxt;
    logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;
    logic             stall_inc, flush_inc;

    logic [6:0] id_op;
    logic [4:0] id_rs1, id_rs2, ex_rd;
    logic       uses_rs1, uses_rs2, lu, rd_ev;

    // Only opcode and register fields are decoded.
    logic unused_bits;
    assign unused_bits = ^{i_ID_inst[31:25], i_ID_inst[14:12], i_ID_inst[11:7],
                           i_EX_inst[31:12], i_EX_inst[6:0]};

    assign id_op  = i_ID_inst[6:0];
    assign id_rs1 = i_ID_inst[19:15];
    assign id_rs2 = i_ID_inst[24:20];
    assign ex_rd  = i_EX_inst[11:7];

    assign uses_rs1 = i_ID_insn_vld &&
                      (id_op != OP_LUI) && (id_op != OP_AUIPC) && (id_op != OP_JAL);
    assign uses_rs2 = i_ID_insn_vld &&
                      ((id_op == OP_R) || (id_op == OP_S) || (id_op == OP_B));

    assign lu = i_EX_insn_vld && i_EX_rd_wren && (i_EX_wb_sel == WB_SEL_LOAD) &&
                (ex_rd != 5'd0) &&
                ((uses_rs1 && (id_rs1 == ex_rd)) || (uses_rs2 && (id_rs2 == ex_rd)));

    assign rd_ev = i_EX_redirect && i_EX_insn_vld;

    always_comb begin
        o_pc_en       = 1'b1;
        o_IF_ID_en    = 1'b1;
        o_IF_ID_flush = 1'b0;
        o_ID_EX_flush = 1'b0;
        state_nxt     = state_q;
        dcnt_nxt      = dcnt_q;
        stall_inc     = 1'b0;
        flush_inc     = 1'b0;

        if (rd_ev) begin
            // Redirect beats any stall; PC/IF-ID stay enabled so the target loads.
            o_IF_ID_flush = 1'b1;
            o_ID_EX_flush = 1'b1;
            flush_inc     = 1'b1;
            if (REDIR_EXTRA > 0) begin
                state_nxt = ST_REDIR;
                dcnt_nxt  = RE_RELOAD;
            end else begin
                state_nxt = ST_RUN;
                dcnt_nxt  = 3'd0;
            end
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (lu) begin
                        o_pc_en       = 1'b0;
                        o_IF_ID_en    = 1'b0;
                        o_ID_EX_flush = 1'b1;
                        stall_inc     = 1'b1;
                        if (LOAD_STALL > 1) begin
                            state_nxt = ST_LDSTALL;
                            dcnt_nxt  = LS_RELOAD;
                        end
                    end
                end
                ST_LDSTALL: begin
                    o_pc_en       = 1'b0;
                    o_IF_ID_en    = 1'b0;
                    o_ID_EX_flush = 1'b1;
                    stall_inc     = 1'b1;
                    dcnt_nxt      = dcnt_q - 3'd1;
                    if (dcnt_q <= 3'd1) begin
                        state_nxt = ST_RUN;
                        dcnt_nxt  = 3'd0;
                    end
                end
                ST_REDIR: begin
                    o_IF_ID_flush = 1'b1;
                    o_ID_EX_flush = 1'b1;
                    dcnt_nxt      = dcnt_q - 3'd1;
                    if (dcnt_q <= 3'd1) begin
                        state_nxt = ST_RUN;
                        dcnt_nxt  = 3'd0;
                    end
                end
                default: begin
                    state_nxt = ST_RUN;
                    dcnt_nxt  = 3'd0;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= ST_RUN;
            dcnt_q      <= 3'd0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q <= state_nxt;
            dcnt_q  <= dcnt_nxt;
            if (stall_inc && (stall_cnt_q != '1))
                stall_cnt_q <= stall_cnt_q + CNT_ONE;
            if (flush_inc && (flush_cnt_q != '1))
                flush_cnt_q <= flush_cnt_q + CNT_ONE;
        end
    end

    assign o_state     = state_q;
    assign o_stall_cnt = stall_cnt_q;
    assign o_flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: two instances with different parameters share one stimulus
// stream. Instance A: LOAD_STALL=1, REDIR_EXTRA=0, CNT_W=32.
// Instance B: LOAD_STALL=3, REDIR_EXTRA=2, CNT_W=4.
module tb_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] id_inst, ex_inst;
    logic        id_vld, ex_wren, ex_vld, ex_redir;
    logic [1:0]  ex_wb;

    logic        a_pc, a_ifid, a_f1, a_f2;
    logic [1:0]  a_state;
    logic [31:0] a_scnt, a_fcnt;
    logic        b_pc, b_ifid, b_f1, b_f2;
    logic [1:0]  b_state;
    logic [3:0]  b_scnt, b_fcnt;

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(.LOAD_STALL(1), .REDIR_EXTRA(0), .WB_SEL_LOAD(2'b01), .CNT_W(32)) u_a (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_ID_inst(id_inst), .i_ID_insn_vld(id_vld),
        .i_EX_inst(ex_inst), .i_EX_rd_wren(ex_wren), .i_EX_wb_sel(ex_wb),
        .i_EX_insn_vld(ex_vld), .i_EX_redirect(ex_redir),
        .o_pc_en(a_pc), .o_IF_ID_en(a_ifid), .o_IF_ID_flush(a_f1), .o_ID_EX_flush(a_f2),
        .o_state(a_state), .o_stall_cnt(a_scnt), .o_flush_cnt(a_fcnt));

    hazard_ctrl #(.LOAD_STALL(3), .REDIR_EXTRA(2), .WB_SEL_LOAD(2'b01), .CNT_W(4)) u_b (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_ID_inst(id_inst), .i_ID_insn_vld(id_vld),
        .i_EX_inst(ex_inst), .i_EX_rd_wren(ex_wren), .i_EX_wb_sel(ex_wb),
        .i_EX_insn_vld(ex_vld), .i_EX_redirect(ex_redir),
        .o_pc_en(b_pc), .o_IF_ID_en(b_ifid), .o_IF_ID_flush(b_f1), .o_ID_EX_flush(b_f2),
        .o_state(b_state), .o_stall_cnt(b_scnt), .o_flush_cnt(b_fcnt));

    // Instruction encodings used by the directed tests.
    localparam logic [31:0] LW_X5   = {12'd0, 5'd1, 3'b010, 5'd5, 7'b0000011};
    localparam logic [31:0] LW_X0   = {12'd0, 5'd1, 3'b010, 5'd0, 7'b0000011};
    localparam logic [31:0] ADD_651 = {7'd0, 5'd1, 5'd5, 3'b000, 5'd6, 7'b0110011};
    localparam logic [31:0] ADD_600 = {7'd0, 5'd0, 5'd0, 3'b000, 5'd6, 7'b0110011};
    localparam logic [31:0] LUI_X5  = {20'h00028, 5'd5, 7'b0110111};  // rs1 field == 5
    localparam logic [31:0] ADDI_I5 = {12'd5, 5'd1, 3'b000, 5'd7, 7'b0010011};
    localparam logic [31:0] BEQ_EX  = {7'd0, 5'd2, 5'd3, 3'b000, 5'd0, 7'b1100011};

    // ---------------- reference model ----------------
    // Tracks how many further stall / shadow cycles remain after the current one.
    int     ls_p[2]  = '{1, 3};
    int     re_p[2]  = '{0, 2};
    longint cmax[2]  = '{64'h0000_0000_FFFF_FFFF, 15};
    int     m_stall_left[2];
    int     m_redir_left[2];
    longint m_sc[2], m_fc[2];

    function automatic bit ref_lu();
        logic [6:0] op;
        bit r1, r2;
        int rd;
        op = id_inst[6:0];
        r1 = id_vld && !(op inside {7'b0110111, 7'b0010111, 7'b1101111});
        r2 = id_vld && (op inside {7'b0110011, 7'b0100011, 7'b1100011});
        rd = int'(ex_inst[11:7]);
        return ex_vld && ex_wren && (ex_wb == 2'b01) && (rd != 0) &&
               ((r1 && int'(id_inst[19:15]) == rd) || (r2 && int'(id_inst[24:20]) == rd));
    endfunction

    function automatic bit ref_redir();
        return ex_redir && ex_vld;
    endfunction

    // {pc_en, IF_ID_en, IF_ID_flush, ID_EX_flush}
    function automatic logic [3:0] exp_out(int d);
        if (!rst_n) return ref_lu() ? 4'b0001 : (ref_redir() ? 4'b1111 : 4'b1100);
        if (ref_redir())          return 4'b1111;
        if (m_redir_left[d] > 0)  return 4'b1111;
        if (m_stall_left[d] > 0 || ref_lu()) return 4'b0001;
        return 4'b1100;
    endfunction

    function automatic logic [1:0] exp_state(int d);
        if (m_stall_left[d] > 0) return 2'd1;
        if (m_redir_left[d] > 0) return 2'd2;
        return 2'd0;
    endfunction

    function automatic logic [3:0] obs_out(int d);
        return (d == 0) ? {a_pc, a_ifid, a_f1, a_f2} : {b_pc, b_ifid, b_f1, b_f2};
    endfunction
    function automatic logic [1:0] obs_state(int d);
        return (d == 0) ? a_state : b_state;
    endfunction
    function automatic logic [63:0] obs_scnt(int d);
        return (d == 0) ? {32'd0, a_scnt} : {60'd0, b_scnt};
    endfunction
    function automatic logic [63:0] obs_fcnt(int d);
        return (d == 0) ? {32'd0, a_fcnt} : {60'd0, b_fcnt};
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_stall_left[d] = 0; m_redir_left[d] = 0; m_sc[d] = 0; m_fc[d] = 0;
        end
    endtask

    task automatic model_step();
        bit lu, rd;
        if (!rst_n) begin
            model_reset();
            return;
        end
        lu = ref_lu();
        rd = ref_redir();
        for (int d = 0; d < 2; d++) begin
            if (rd) begin
                if (m_fc[d] < cmax[d]) m_fc[d]++;
                m_redir_left[d] = re_p[d];
                m_stall_left[d] = 0;
            end else if (m_redir_left[d] > 0) begin
                m_redir_left[d]--;
            end else if (m_stall_left[d] > 0) begin
                m_stall_left[d]--;
                if (m_sc[d] < cmax[d]) m_sc[d]++;
            end else if (lu) begin
                m_stall_left[d] = ls_p[d] - 1;
                if (m_sc[d] < cmax[d]) m_sc[d]++;
            end
        end
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic set_in(input logic [31:0] idi, input logic idv, input logic [31:0] exi,
                          input logic wren, input logic [1:0] wb, input logic exv,
                          input logic redir);
        id_inst = idi; id_vld = idv; ex_inst = exi;
        ex_wren = wren; ex_wb = wb; ex_vld = exv; ex_redir = redir;
        #1;
    endtask

    task automatic set_idle();
        set_in(ADDI_I5, 1'b1, BEQ_EX, 1'b0, 2'b00, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        set_idle();
        tick();
        tick();
        rst_n = 1'b1;
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        model_reset();
        set_in(ADD_651, 1'b1, LW_X5, 1'b1, 2'b01, 1'b1, 1'b0);
        tick();
        #1;
        for (int d = 0; d < 2; d++) begin
            checks++;
            if (obs_state(d) !== 2'd0 || obs_scnt(d) !== 64'd0 || obs_fcnt(d) !== 64'd0)
                $display("FAIL reset_regs dut%0d: state=%0d stall=%0d flush=%0d required 0/0/0",
                         d, obs_state(d), obs_scnt(d), obs_fcnt(d));
            else passes++;
            checks++;
            if (obs_out(d) !== 4'b0001)
                $display("FAIL reset_run_decode dut%0d: outs=%b required 0001", d, obs_out(d));
            else passes++;
        end
        rst_n = 1'b1;
        set_idle();
    endtask

    task automatic test_load_use();
        int a_pc_e[4] = '{0, 1, 1, 1};
        int b_st_e[4] = '{0, 1, 1, 0};
        int b_pc_e[4] = '{0, 0, 0, 1};
        do_reset();
        set_in(ADD_651, 1'b1, LW_X5, 1'b1, 2'b01, 1'b1, 1'b0);
        for (int c = 0; c < 4; c++) begin
            checks++;
            if (a_pc !== 1'(a_pc_e[c]) || a_ifid !== 1'(a_pc_e[c]) ||
                a_f2 !== 1'(1 - a_pc_e[c]) || a_f1 !== 1'b0 || a_state !== 2'd0)
                $display("FAIL lu1_cycle%0d: pc=%b ifid=%b f1=%b f2=%b st=%0d required pc=%0d",
                         c, a_pc, a_ifid, a_f1, a_f2, a_state, a_pc_e[c]);
            else passes++;
            checks++;
            if (b_state !== 2'(b_st_e[c]) || b_pc !== 1'(b_pc_e[c]) || b_f2 !== 1'(1 - b_pc_e[c]))
                $display("FAIL lu3_cycle%0d: state=%0d pc=%b f2=%b required state=%0d pc=%0d",
                         c, b_state, b_pc, b_f2, b_st_e[c], b_pc_e[c]);
            else passes++;
            tick();
            if (c == 0) set_idle();
        end
        #1;
        checks++;
        if (a_scnt !== 32'd1 || b_scnt !== 4'd3 || a_fcnt !== 32'd0)
            $display("FAIL lu_counts: a_stall=%0d b_stall=%0d a_flush=%0d required 1/3/0",
                     a_scnt, b_scnt, a_fcnt);
        else passes++;
    endtask

    task automatic test_no_stall();
        logic [31:0] ex_l[3] = '{LW_X0, LW_X5, LW_X5};
        logic [31:0] id_l[3] = '{ADD_600, LUI_X5, ADDI_I5};
        do_reset();
        for (int k = 0; k < 3; k++) begin
            set_in(id_l[k], 1'b1, ex_l[k], 1'b1, 2'b01, 1'b1, 1'b0);
            checks++;
            if ({a_pc, a_ifid, a_f1, a_f2} !== 4'b1100 || {b_pc, b_ifid, b_f1, b_f2} !== 4'b1100)
                $display("FAIL no_stall_case%0d: a=%b b=%b required 1100", k,
                         {a_pc, a_ifid, a_f1, a_f2}, {b_pc, b_ifid, b_f1, b_f2});
            else passes++;
            tick();
        end
        #1;
        checks++;
        if (a_scnt !== 32'd0 || b_scnt !== 4'd0 || b_state !== 2'd0)
            $display("FAIL no_stall_counts: a=%0d b=%0d bstate=%0d required 0/0/0",
                     a_scnt, b_scnt, b_state);
        else passes++;
    endtask

    task automatic test_redirect();
        int b_st_e[4] = '{0, 2, 2, 0};
        do_reset();
        set_in(ADDI_I5, 1'b1, BEQ_EX, 1'b0, 2'b00, 1'b1, 1'b1);
        for (int c = 0; c < 4; c++) begin
            checks++;
            if (b_state !== 2'(b_st_e[c]) ||
                {b_pc, b_ifid, b_f1, b_f2} !== ((c < 3) ? 4'b1111 : 4'b1100))
                $display("FAIL redir_b_cycle%0d: state=%0d outs=%b required state=%0d",
                         c, b_state, {b_pc, b_ifid, b_f1, b_f2}, b_st_e[c]);
            else passes++;
            checks++;
            if (a_state !== 2'd0 || {a_pc, a_ifid, a_f1, a_f2} !== ((c == 0) ? 4'b1111 : 4'b1100))
                $display("FAIL redir_a_cycle%0d: state=%0d outs=%b", c, a_state,
                         {a_pc, a_ifid, a_f1, a_f2});
            else passes++;
            tick();
            if (c == 0) set_idle();
        end
        #1;
        checks++;
        if (a_fcnt !== 32'd1 || b_fcnt !== 4'd1)
            $display("FAIL redir_counts: a_flush=%0d b_flush=%0d required 1/1", a_fcnt, b_fcnt);
        else passes++;
    endtask

    task automatic test_simultaneous();
        do_reset();
        set_in(ADD_651, 1'b1, LW_X5, 1'b1, 2'b01, 1'b1, 1'b1);
        checks++;
        if ({a_pc, a_ifid, a_f1, a_f2} !== 4'b1111 || {b_pc, b_ifid, b_f1, b_f2} !== 4'b1111)
            $display("FAIL lu_and_redir_outs: a=%b b=%b required 1111",
                     {a_pc, a_ifid, a_f1, a_f2}, {b_pc, b_ifid, b_f1, b_f2});
        else passes++;
        tick();
        set_idle();
        checks++;
        if (a_scnt !== 32'd0 || b_scnt !== 4'd0 || a_fcnt !== 32'd1 || b_fcnt !== 4'd1 ||
            b_state !== 2'd2)
            $display("FAIL lu_and_redir_counts: stall=%0d/%0d flush=%0d/%0d bstate=%0d required 0/0 1/1 2",
                     a_scnt, b_scnt, a_fcnt, b_fcnt, b_state);
        else passes++;
        // Redirect arriving in LDSTALL aborts the stall immediately.
        do_reset();
        set_in(ADD_651, 1'b1, LW_X5, 1'b1, 2'b01, 1'b1, 1'b0);
        tick();
        set_in(ADDI_I5, 1'b1, BEQ_EX, 1'b0, 2'b00, 1'b1, 1'b1);
        checks++;
        if (b_state !== 2'd1 || {b_pc, b_ifid, b_f1, b_f2} !== 4'b1111)
            $display("FAIL ldstall_abort_outs: state=%0d outs=%b required 1/1111",
                     b_state, {b_pc, b_ifid, b_f1, b_f2});
        else passes++;
        tick();
        set_idle();
        checks++;
        if (b_state !== 2'd2 || b_scnt !== 4'd1 || b_fcnt !== 4'd1)
            $display("FAIL ldstall_abort_after: state=%0d stall=%0d flush=%0d required 2/1/1",
                     b_state, b_scnt, b_fcnt);
        else passes++;
    endtask

    task automatic test_reset_mid_stall();
        do_reset();
        set_in(ADD_651, 1'b1, LW_X5, 1'b1, 2'b01, 1'b1, 1'b0);
        tick();
        set_idle();
        checks++;
        if (b_state !== 2'd1)
            $display("FAIL mid_stall_setup: state=%0d required 1", b_state);
        else passes++;
        rst_n = 1'b0;
        #1;
        checks++;
        if (b_state !== 2'd0 || b_scnt !== 4'd0 || a_scnt !== 32'd0 ||
            {b_pc, b_ifid, b_f1, b_f2} !== 4'b1100)
            $display("FAIL reset_mid_stall: state=%0d stall=%0d/%0d outs=%b required 0 0/0 1100",
                     b_state, a_scnt, b_scnt, {b_pc, b_ifid, b_f1, b_f2});
        else passes++;
        model_reset();
        tick();
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_saturation();
        do_reset();
        set_in(ADD_651, 1'b1, LW_X5, 1'b1, 2'b01, 1'b1, 1'b0);
        for (int c = 0; c < 20; c++) tick();
        set_idle();
        tick();
        tick();
        checks++;
        if (b_scnt !== 4'd15 || a_scnt !== 32'd20)
            $display("FAIL stall_saturation: b=%0d a=%0d required 15/20", b_scnt, a_scnt);
        else passes++;
    endtask

    task automatic test_random();
        logic [6:0] ops[9] = '{7'b0110011, 7'b0100011, 7'b1100011, 7'b0110111, 7'b0010111,
                               7'b1101111, 7'b0000011, 7'b0010011, 7'b1100111};
        logic [31:0] idi, exi;
        int errs = 0;
        do_reset();
        for (int n = 0; n < 400; n++) begin
            idi = $urandom;
            idi[6:0]   = ops[$urandom_range(0, 8)];
            idi[19:15] = 5'($urandom_range(0, 3));
            idi[24:20] = 5'($urandom_range(0, 3));
            exi = $urandom;
            exi[11:7]  = 5'($urandom_range(0, 3));
            set_in(idi, 1'($urandom_range(0, 99) < 85), exi, 1'($urandom_range(0, 1)),
                   ($urandom_range(0, 1) == 1) ? 2'b01 : 2'($urandom_range(0, 3)),
                   1'($urandom_range(0, 99) < 85), 1'($urandom_range(0, 99) < 8));
            for (int d = 0; d < 2; d++) begin
                checks++;
                if (obs_out(d) !== exp_out(d) || obs_state(d) !== exp_state(d) ||
                    obs_scnt(d) !== 64'(m_sc[d]) || obs_fcnt(d) !== 64'(m_fc[d])) begin
                    errs++;
                    if (errs < 10)
                        $display("FAIL random_n%0d_dut%0d: outs=%b st=%0d stall=%0d flush=%0d required outs=%b st=%0d stall=%0d flush=%0d",
                                 n, d, obs_out(d), obs_state(d), obs_scnt(d), obs_fcnt(d),
                                 exp_out(d), exp_state(d), m_sc[d], m_fc[d]);
                end else passes++;
            end
            tick();
        end
    endtask

    initial begin
        rst_n = 1'b0;
        model_reset();
        set_idle();
        @(negedge clk);
        test_reset();
        test_load_use();
        test_no_stall();
        test_redirect();
        test_simultaneous();
        test_reset_mid_stall();
        test_saturation();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
